// File: rtl/bit_count_unit_pkg.sv
// Shared types and constants for the bit count unit.
//  bc_op_t        : operation select carried through stage 1
//  BC_DATA_W      : operand width
//  BC_RES_W       : internal result width (0..32 needs 6 bits)
//  bc_bit_reverse : bit k -> bit (BC_DATA_W-1-k), turns CLZ into a trailing scan
package bmu_pkg;

  typedef enum logic [1:0] {
    BC_CLZ  = 2'b00,
    BC_CTZ  = 2'b01,
    BC_CPOP = 2'b10,
    BC_RSVD = 2'b11
  } bc_op_t;

  localparam int BC_DATA_W = 32;
  localparam int BC_RES_W  = 6;
  localparam int BC_BYTES  = BC_DATA_W / 8;

  function automatic logic [BC_DATA_W-1:0] bc_bit_reverse(input logic [BC_DATA_W-1:0] d);
    logic [BC_DATA_W-1:0] r;
    for (int k = 0; k < BC_DATA_W; k++) begin
      r[k] = d[BC_DATA_W-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_count_unit_if.sv
// Request/response handshake bundle for the bit count unit.
//  Request  : valid_i, ready_o, op_i, data_i, tag_i
//  Response : valid_o, ready_i, result_o, tag_o
//  master = issue/writeback side, slave = the count unit.
interface bit_count_unit_if #(
  parameter int TAG_W = 6
);
  import bmu_pkg::*;

  logic                 valid_i;
  logic                 ready_o;
  logic [1:0]           op_i;
  logic [BC_DATA_W-1:0] data_i;
  logic [TAG_W-1:0]     tag_i;

  logic                 valid_o;
  logic                 ready_i;
  logic [BC_DATA_W-1:0] result_o;
  logic [TAG_W-1:0]     tag_o;

  modport master (
    output valid_i, op_i, data_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, op_i, data_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

endinterface

// File: rtl/bit_count_unit_byte_count.sv
// Per-byte counting blocks.
//  clz8          : trailing-zero count of one byte, scanning from bit 0 upward;
//                  returns 8 when the byte is zero.
//                  ports: data[7:0] in, count[3:0] out
//  bc_byte_count : clz8 plus an 8-bit popcount for one byte.
//                  ports: data[7:0] in, counts[7:0] out = {tz[3:0], pop[3:0]}
module clz8 (
  input  logic [7:0] data,
  output logic [3:0] count
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    count = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (data[k]) begin
        count = 4'(k);
      end
    end
  end

endmodule

module bc_byte_count
  import bmu_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] counts
);

  logic [3:0] tz;
  logic [3:0] pop;

  clz8 u_clz8 (
    .data  (data),
    .count (tz)
  );

  always_comb begin
    pop = 4'd0;
    for (int k = 0; k < 8; k++) begin
      pop = pop + {3'b000, data[k]};
    end
  end

  assign counts = {tz, pop};

endmodule

// File: rtl/bit_count_unit.sv
// Two-stage pipelined count unit: CLZ, CTZ and CPOP on a 32-bit operand.
//  cpu_clock_i   : core clock
//  cpu_reset_n_i : asynchronous active-low reset
//  flush_i       : kills everything in flight at the next edge
//  bus (slave)   : request valid_i/ready_o/op_i/data_i/tag_i,
//                  response valid_o/ready_i/result_o/tag_o
// Stage 1 holds the accepted request; its count is computed combinationally
// and captured into stage 2, which drives the outputs directly.
module bit_count_unit
  import bmu_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic       cpu_clock_i,
  input  logic       cpu_reset_n_i,
  input  logic       flush_i,
  bit_count_unit_if.slave bus
);

  // Stage 1 state
  logic                 s1_valid_reg;
  bc_op_t               s1_op_reg;
  logic [BC_DATA_W-1:0] s1_data_reg;
  logic [TAG_W-1:0]     s1_tag_reg;

  // Stage 2 state (output stage)
  logic                 s2_valid_reg;
  logic [BC_RES_W-1:0]  s2_result_reg;
  logic [TAG_W-1:0]     s2_tag_reg;

  logic s2_adv;
  logic accept;
  logic s2_load;
  logic s1_valid_next;
  logic s2_valid_next;

  // Stage 2 can take new data when it is empty or being drained this cycle.
  assign s2_adv  = !s2_valid_reg || bus.ready_i;
  assign bus.ready_o = !s1_valid_reg || s2_adv;
  assign accept  = bus.valid_i && bus.ready_o;
  assign s2_load = s1_valid_reg && s2_adv && !flush_i;

  // Flush dominates both a new accept and a same-cycle retire.
  always_comb begin
    s1_valid_next = s1_valid_reg && !s2_adv;
    s2_valid_next = s2_adv ? s1_valid_reg : s2_valid_reg;
    if (accept) begin
      s1_valid_next = 1'b1;
    end
    if (flush_i) begin
      s1_valid_next = 1'b0;
      s2_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 datapath
  // ---------------------------------------------------------------------
  // CLZ is turned into a trailing-zero scan by reversing the operand, so
  // the same per-byte LSB-first counters serve both CLZ and CTZ.
  logic [BC_DATA_W-1:0]       operand;
  logic [BC_BYTES-1:0][7:0]   byte_counts;
  logic [BC_RES_W-1:0]        scan_count;
  logic [4:0]                 pop_lo;
  logic [4:0]                 pop_hi;
  logic [BC_RES_W-1:0]        pop_sum;
  logic [BC_RES_W-1:0]        s1_result;

  assign operand = (s1_op_reg == BC_CLZ) ? bc_bit_reverse(s1_data_reg) : s1_data_reg;

  generate
    for (genvar gi = 0; gi < BC_BYTES; gi++) begin : g_byte
      bc_byte_count u_byte_count (
        .data   (operand[8*gi +: 8]),
        .counts (byte_counts[gi])
      );
    end
  endgenerate

  // Lowest byte with any set bit decides the count; all-zero gives 32.
  always_comb begin
    scan_count = 6'd32;
    for (int i = BC_BYTES - 1; i >= 0; i--) begin
      if (byte_counts[i][7:4] != 4'd8) begin
        scan_count = 6'(8 * i) + {2'b00, byte_counts[i][7:4]};
      end
    end
  end

  // Two-level adder tree over the per-byte popcounts.
  assign pop_lo  = {1'b0, byte_counts[0][3:0]} + {1'b0, byte_counts[1][3:0]};
  assign pop_hi  = {1'b0, byte_counts[2][3:0]} + {1'b0, byte_counts[3][3:0]};
  assign pop_sum = {1'b0, pop_lo} + {1'b0, pop_hi};

  always_comb begin
    s1_result = '0;
    case (s1_op_reg)
      BC_CLZ, BC_CTZ: s1_result = scan_count;
      BC_CPOP:        s1_result = pop_sum;
      default:        s1_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= BC_CLZ;
      s1_data_reg  <= '0;
      s1_tag_reg   <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      if (accept) begin
        s1_op_reg   <= bc_op_t'(bus.op_i);
        s1_data_reg <= bus.data_i;
        s1_tag_reg  <= bus.tag_i;
      end
    end
  end

  // Result/tag only change when a new op lands, so they stay stable while
  // the consumer stalls and keep their old value after a flush.
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_tag_reg    <= '0;
    end else begin
      s2_valid_reg <= s2_valid_next;
      if (s2_load) begin
        s2_result_reg <= s1_result;
        s2_tag_reg    <= s1_tag_reg;
      end
    end
  end

  assign bus.valid_o  = s2_valid_reg;
  assign bus.result_o = {{(BC_DATA_W - BC_RES_W){1'b0}}, s2_result_reg};
  assign bus.tag_o    = s2_tag_reg;

endmodule
